// File: rtl/cap_sched_pkg.sv
// Shared definitions for the I/Q capture scheduler: state encoding,
// requester indices and the default frame depth.
package cap_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FLUSH   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_KICK    = 3'd4,
        ST_DRAIN   = 3'd5,
        ST_ACK     = 3'd6
    } cap_state_e;

    localparam int HOST      = 0;
    localparam int DSP       = 1;
    localparam int CAP_DEPTH = 120;

    // Requester index to one-hot grant/ack vector.
    function automatic logic [1:0] idx2oh(input logic idx);
        idx2oh = idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/cap_rr_arb2.sv
// Two-way round-robin arbiter. The last-served pointer moves only when the
// scheduler retires a frame, so the winner is stable for the whole IDLE cycle.
module cap_rr_arb2
    import cap_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rstb,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       served,
    output logic       win
);

    logic last_q, last_d;

    // Remember who was served when the frame is acknowledged.
    always_comb begin
        last_d = upd ? served : last_q;
    end

    // Pointer starts at DSP so the host wins the first contention.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) last_q <= 1'(DSP);
        else       last_q <= last_d;
    end

    // Single requester wins outright; on contention the one not served last wins.
    always_comb begin
        case (req)
            2'b10:   win = 1'(DSP);
            2'b11:   win = ~last_q;
            default: win = 1'(HOST);
        endcase
    end

endmodule

// File: rtl/cap_sched.sv
// Capture/readout scheduler: grants the shared capture buffer, gates the
// sample enable for exactly one frame, kicks readout and waits for it.
module cap_sched
    import cap_sched_pkg::*;
#(
    parameter int DEPTH   = CAP_DEPTH,
    parameter int SKIP    = 0,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic [1:0] req,
    input  logic       sample_valid_in,
    input  logic       mem_out_done,
    output logic       cap_en_out,
    output logic       mem_done,
    output logic [1:0] gnt,
    output logic [1:0] ack,
    output logic       timeout_o,
    output logic       busy
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] SKIP_LAST  = CNT_W'((SKIP > 0) ? SKIP - 1 : 0);
    localparam logic [CNT_W-1:0] DEPTH_LAST = CNT_W'(DEPTH - 1);
    localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT - 1);

    cap_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             settle_q, settle_d;
    logic             owner_q, owner_d;
    logic             to_q, to_d;
    logic             win;
    logic             wd_exp;

    assign wd_exp = (wd_q == WD_LAST);

    cap_rr_arb2 u_arb (
        .clk    (clk),
        .rstb   (rstb),
        .req    (req),
        .upd    (state_q == ST_ACK),
        .served (owner_q),
        .win    (win)
    );

    // State and bookkeeping registers; reset mid-frame simply abandons it.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            wd_q     <= '0;
            settle_q <= 1'b0;
            owner_q  <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wd_q     <= wd_d;
            settle_q <= settle_d;
            owner_q  <= owner_d;
            to_q     <= to_d;
        end
    end

    // Next-state: req is only looked at in IDLE, so mid-frame drops are ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (|req) state_d = (SKIP == 0) ? ST_CAPTURE : ST_FLUSH;
            ST_FLUSH:   if (sample_valid_in && cnt_q == SKIP_LAST) state_d = ST_CAPTURE;
            ST_CAPTURE: if (sample_valid_in && cnt_q == DEPTH_LAST) state_d = ST_SETTLE;
            ST_SETTLE:  if (settle_q) state_d = ST_KICK;
            ST_KICK:    state_d = ST_DRAIN;
            ST_DRAIN:   if (mem_out_done || wd_exp) state_d = ST_ACK;
            ST_ACK:     state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Counters clear on every state change; SETTLE waits out the buffer's
    // two-stage write path before the readout kick.
    always_comb begin
        cnt_d    = cnt_q;
        wd_d     = wd_q;
        settle_d = settle_q;
        owner_d  = owner_q;
        to_d     = to_q;
        if (state_d != state_q) begin
            cnt_d    = '0;
            wd_d     = '0;
            settle_d = 1'b0;
        end else begin
            if ((state_q == ST_FLUSH || state_q == ST_CAPTURE) && sample_valid_in)
                cnt_d = cnt_q + 1'b1;
            if (state_q == ST_DRAIN)
                wd_d = wd_q + 1'b1;
            if (state_q == ST_SETTLE)
                settle_d = 1'b1;
        end
        if (state_q == ST_IDLE && |req)
            owner_d = win;
        // A real out_done on the expiry cycle counts as a normal completion.
        if (state_q == ST_DRAIN)
            to_d = wd_exp && !mem_out_done;
    end

    // Outputs decode straight from the state register; the enable is the
    // only write path into the buffer.
    always_comb begin
        busy       = (state_q != ST_IDLE);
        cap_en_out = sample_valid_in && (state_q == ST_CAPTURE);
        mem_done   = (state_q == ST_KICK);
        gnt        = busy ? idx2oh(owner_q) : 2'b00;
        ack        = (state_q == ST_ACK) ? idx2oh(owner_q) : 2'b00;
        timeout_o  = (state_q == ST_ACK) && to_q;
    end

endmodule

// File: tb/tb_cap_sched.sv
// Bench for cap_sched: two instances (SKIP=0 and SKIP=4) beside a capture
// buffer model with a fixed-latency readout; acks are scored against a queue.
module tb_cap_sched;
    import cap_sched_pkg::*;

    localparam int DEPTH = CAP_DEPTH;
    localparam int TMO   = 255;

    typedef struct {
        int         unit;
        logic [1:0] ack;
        logic       to;
    } exp_t;

    typedef struct {
        logic [1:0] req;
        logic [1:0] gnt;
        bit         autod;
    } vec_t;

    logic       clk, rstb;
    logic [1:0] req [2];
    logic       svi [2];
    logic       stray [2];
    logic       model_done [2];
    logic       mdi [2];
    logic       cap_en [2];
    logic       mem_done_o [2];
    logic [1:0] gnt [2];
    logic [1:0] ack [2];
    logic       to_o [2];
    logic       busy [2];

    int   checks, fails, cyc, ph;
    int   wp [2], snum [2], fen [2], nmd [2], last_en [2], md_cyc [2];
    int   rd_left [2], n_ack [2];
    bit   busy_prev [2], post_ack [2], auto_d [2], sparse [2];
    int   mem [2][DEPTH];
    exp_t sbq [$];
    vec_t tbl [8];
    int   tgt, errs, t0;

    assign mdi[0] = model_done[0] | stray[0];
    assign mdi[1] = model_done[1] | stray[1];

    cap_sched #(.DEPTH(DEPTH), .SKIP(0), .CNT_W(8), .TIMEOUT(TMO)) u_dut0 (
        .clk(clk), .rstb(rstb), .req(req[0]), .sample_valid_in(svi[0]),
        .mem_out_done(mdi[0]), .cap_en_out(cap_en[0]), .mem_done(mem_done_o[0]),
        .gnt(gnt[0]), .ack(ack[0]), .timeout_o(to_o[0]), .busy(busy[0])
    );

    cap_sched #(.DEPTH(DEPTH), .SKIP(4), .CNT_W(8), .TIMEOUT(TMO)) u_dut4 (
        .clk(clk), .rstb(rstb), .req(req[1]), .sample_valid_in(svi[1]),
        .mem_out_done(mdi[1]), .cap_en_out(cap_en[1]), .mem_done(mem_done_o[1]),
        .gnt(gnt[1]), .ack(ack[1]), .timeout_o(to_o[1]), .busy(busy[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [7:0] outs(input int u);
        outs = {cap_en[u], mem_done_o[u], gnt[u], ack[u], to_o[u], busy[u]};
    endfunction

    task automatic wait_ack(input int u, input int target, input int budget);
        int n;
        n = 0;
        while (n_ack[u] < target && n < budget) begin
            tick();
            n++;
        end
        if (n_ack[u] < target) chk("ack_wait_expired", n_ack[u], target);
    endtask

    task automatic wait_fen(input int u, input int target, input int budget);
        int n;
        n = 0;
        while (fen[u] < target && n < budget) begin
            tick();
            n++;
        end
        if (fen[u] < target) chk("capture_wait_expired", fen[u], target);
    endtask

    task automatic wait_idle(input int u, input int budget);
        int n;
        n = 0;
        while (busy[u] && n < budget) begin
            tick();
            n++;
        end
        if (busy[u]) chk("idle_wait_expired", busy[u], 0);
    endtask

    // Sample strobes: continuous, or every third cycle in sparse mode.
    initial begin
        ph = 0;
        svi[0] = 1'b0;
        svi[1] = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ph++;
            for (int u = 0; u < 2; u++) svi[u] = sparse[u] ? (ph % 3 == 0) : 1'b1;
        end
    end

    // Buffer model, readout model and scoreboard, evaluated mid-cycle.
    initial begin
        model_done[0] = 1'b0;
        model_done[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                if (!rstb) begin
                    wp[u] = 0; rd_left[u] = 0; model_done[u] = 1'b0;
                    post_ack[u] = 1'b0; busy_prev[u] = 1'b0;
                    continue;
                end
                if (post_ack[u]) begin
                    chk("idle_after_ack", int'({busy[u], gnt[u]}), 0);
                    post_ack[u] = 1'b0;
                end
                if (busy[u] && !busy_prev[u]) begin
                    snum[u] = 0; fen[u] = 0; nmd[u] = 0;
                end
                if (busy[u] && svi[u]) snum[u]++;
                if (cap_en[u]) begin
                    mem[u][wp[u]] = snum[u];
                    wp[u] = (wp[u] + 1) % DEPTH;
                    fen[u]++;
                    last_en[u] = cyc;
                end
                model_done[u] = 1'b0;
                if (rd_left[u] > 0) begin
                    rd_left[u]--;
                    if (rd_left[u] == 0) model_done[u] = 1'b1;
                end
                if (mem_done_o[u]) begin
                    nmd[u]++;
                    md_cyc[u] = cyc;
                    if (auto_d[u]) rd_left[u] = DEPTH + 1;
                end
                if (ack[u] != 2'b00) begin
                    n_ack[u]++;
                    post_ack[u] = 1'b1;
                    if (sbq.size() == 0 || sbq[0].unit != u) begin
                        chk("unexpected_ack", int'(ack[u]), 0);
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        chk("ack_owner", int'(ack[u]), int'(e.ack));
                        chk("timeout_flag", int'(to_o[u]), int'(e.to));
                        chk("frame_en_pulses", fen[u], DEPTH);
                        chk("mem_done_pulses", nmd[u], 1);
                        chk("kick_after_last_en", md_cyc[u] - last_en[u], 3);
                        chk("ack_after_kick", cyc - md_cyc[u], e.to ? TMO + 1 : DEPTH + 2);
                    end
                end
                busy_prev[u] = busy[u];
            end
        end
    end

    initial begin
        checks = 0; fails = 0;
        rstb = 1'b0;
        for (int u = 0; u < 2; u++) begin
            req[u] = 2'b00; stray[u] = 1'b0; auto_d[u] = 1'b1; sparse[u] = 1'b0;
            n_ack[u] = 0; fen[u] = 0;
        end
        tbl[0] = '{2'b01, 2'b01, 1'b1};
        tbl[1] = '{2'b11, 2'b10, 1'b1};
        tbl[2] = '{2'b11, 2'b01, 1'b1};
        tbl[3] = '{2'b10, 2'b10, 1'b1};
        tbl[4] = '{2'b11, 2'b01, 1'b1};
        tbl[5] = '{2'b01, 2'b01, 1'b0};
        tbl[6] = '{2'b11, 2'b10, 1'b1};
        tbl[7] = '{2'b01, 2'b01, 1'b1};

        repeat (3) tick();
        chk("reset_outputs_u0", int'(outs(0)), 0);
        chk("reset_outputs_u1", int'(outs(1)), 0);
        rstb = 1'b1;
        tick();

        // Contention held from reset: host, DSP, host, one IDLE cycle between.
        req[0] = 2'b11;
        sbq.push_back('{0, 2'b01, 1'b0});
        sbq.push_back('{0, 2'b10, 1'b0});
        sbq.push_back('{0, 2'b01, 1'b0});
        tick();
        chk("contend_gnt0", int'(gnt[0]), 1);
        wait_ack(0, 1, 1000);
        chk("contend_gap1", int'(busy[0]), 0);
        tick();
        chk("contend_gnt1", int'(gnt[0]), 2);
        wait_ack(0, 2, 1000);
        chk("contend_gap2", int'(busy[0]), 0);
        tick();
        chk("contend_gnt2", int'(gnt[0]), 1);
        req[0] = 2'b00;
        wait_ack(0, 3, 1000);

        // Table of single-frame requests, including one watchdog expiry.
        for (int i = 0; i < 8; i++) begin
            tgt = n_ack[0] + 1;
            wait_idle(0, 50);
            auto_d[0] = tbl[i].autod;
            req[0] = tbl[i].req;
            tick();
            req[0] = 2'b00;
            chk("vec_gnt", int'(gnt[0]), int'(tbl[i].gnt));
            chk("vec_busy", int'(busy[0]), 1);
            chk("vec_first_en", int'(cap_en[0]), 1);
            sbq.push_back('{0, tbl[i].gnt, !tbl[i].autod});
            wait_ack(0, tgt, 1000);
        end
        auto_d[0] = 1'b1;

        // Host drops req mid-capture while a stray out_done arrives.
        tgt = n_ack[0] + 1;
        req[0] = 2'b01;
        tick();
        chk("stray_gnt", int'(gnt[0]), 1);
        sbq.push_back('{0, 2'b01, 1'b0});
        wait_fen(0, 30, 500);
        req[0] = 2'b00;
        stray[0] = 1'b1;
        tick();
        stray[0] = 1'b0;
        wait_ack(0, tgt, 1000);

        // Reset in mid-capture: silent abort, next frame starts at address 0.
        t0 = n_ack[0];
        req[0] = 2'b01;
        tick();
        req[0] = 2'b00;
        wait_fen(0, 60, 500);
        rstb = 1'b0;
        #1;
        chk("midframe_reset_outputs", int'(outs(0)), 0);
        tick();
        tick();
        rstb = 1'b1;
        repeat (3) tick();
        chk("no_ack_after_reset", n_ack[0], t0);
        req[0] = 2'b01;
        tick();
        req[0] = 2'b00;
        chk("post_reset_gnt", int'(gnt[0]), 1);
        sbq.push_back('{0, 2'b01, 1'b0});
        wait_ack(0, t0 + 1, 1000);
        errs = 0;
        for (int a = 0; a < DEPTH; a++) if (mem[0][a] != a + 1) errs++;
        chk("buffer_after_reset_errs", errs, 0);
        chk("buffer_after_reset_addr0", mem[0][0], 1);

        // Sparse strobes with SKIP=4: strobes 5..124 land at addresses 0..119.
        sparse[1] = 1'b1;
        tick();
        tgt = n_ack[1] + 1;
        req[1] = 2'b01;
        tick();
        req[1] = 2'b00;
        chk("sparse_gnt", int'(gnt[1]), 1);
        sbq.push_back('{1, 2'b01, 1'b0});
        wait_ack(1, tgt, 3000);
        errs = 0;
        for (int a = 0; a < DEPTH; a++) if (mem[1][a] != a + 5) errs++;
        chk("sparse_buffer_errs", errs, 0);
        chk("sparse_buffer_addr0", mem[1][0], 5);
        chk("sparse_buffer_last", mem[1][DEPTH-1], DEPTH + 4);

        repeat (3) tick();
        chk("scoreboard_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/cap_sched.md
# cap_sched

Capture/readout scheduler for the 18x120 I/Q capture buffer. Two clients share the single buffer: the host (req[0]) and the DSP monitor (req[1]). The block grants the buffer round-robin and gates the SAT9 sample enable so that exactly one frame is written. It then kicks the buffer's readout with a one-cycle done and waits for the buffer's out_done. It sits between the SAT9 saturator output and the capture buffer, beside the register interface that raises the requests.

## Interface
- DEPTH, 120: samples per frame; must equal the buffer depth so the buffer write pointer realigns to 0 after every frame.
- SKIP, 0: samples discarded after grant, before capture (settling); 0 bypasses FLUSH.
- CNT_W, 8: width of the sample counter; must hold max(DEPTH, SKIP).
- TIMEOUT, 255: cycles allowed in DRAIN before forced release.
- clk  in  1  system clock, rising edge.
- rstb  in  1  asynchronous active-low reset.
- req  in  2  level requests; req[0] is host, req[1] is DSP.
- sample_valid_in  in  1  upstream SAT9 sample strobe.
- mem_out_done  in  1  buffer out_done, a pulse on the last read word.
- cap_en_out  out  1  gated sample enable to the buffer's SAT9_en.
- mem_done  out  1  one-cycle readout kick to the buffer's done.
- gnt  out  2  one-hot owner; held from grant through ACK.
- ack  out  2  one-cycle completion pulse to the owner.
- timeout_o  out  1  one-cycle pulse, coincident with ack, when DRAIN expired.
- busy  out  1  high in every state except IDLE.

## Operation
- States and transitions:
  - IDLE → FLUSH or CAPTURE: any req high.
  - FLUSH → CAPTURE: after SKIP sample_valid_in strobes.
  - CAPTURE → SETTLE: after DEPTH strobes.
  - SETTLE → KICK: after 2 cycles.
  - KICK → DRAIN: always.
  - DRAIN → ACK: mem_out_done, or the watchdog reaches TIMEOUT.
  - ACK → IDLE: always.
- Arbitration is evaluated only in IDLE.
  - A single request wins outright.
  - When both are high, the requester not served last wins.
  - The last-served pointer resets to 1, so req[0] wins the first contention.
- req is sampled only in IDLE. Deasserting req mid-service is ignored: the frame completes and ack still pulses.
- A requester must drop req in the cycle after ack; otherwise it is treated as a new request.
- cap_en_out = sample_valid_in & (state==CAPTURE). It is combinational from the state register and is the only path to the buffer write enable. The buffer is never written outside CAPTURE, including while it is being read.
- Sample counter:
  - Cleared on every state entry.
  - Increments on sample_valid_in in FLUSH and CAPTURE.
  - Terminal compare is count==N-1 with a strobe present.
- SETTLE covers the buffer's two-stage write latency (registered input, then array write). The last frame word is therefore in memory before done.
- Watchdog counter runs only in DRAIN. Expiry does not abort the buffer readout. cap_sched stays out of CAPTURE until the next grant, which is at least 2 cycles later.
- mem_out_done outside DRAIN is ignored.

## Timing
- Reset value of every output is 0: cap_en_out, mem_done, gnt, ack, timeout_o, busy. State resets to IDLE, counters to 0, last-served pointer to 1.
- Reset mid-frame aborts without ack. The buffer shares rstb, so its pointers realign.
- Request latency: req high at edge n in IDLE → gnt and busy high after edge n+1. cap_en_out can pass a strobe in cycle n+1 when SKIP=0.
- Frame latency:
  - Last captured strobe in cycle t.
  - mem_done high in cycle t+3.
  - mem_out_done at cycle d.
  - ack and timeout_o high in cycle d+1.
  - gnt low and IDLE at d+2.
- Throughput: back-to-back grants are separated by exactly one IDLE cycle.

## Structure
- The shared capture package holds:
  - The state encoding constants (7 states, 3-bit).
  - The requester index constants HOST=0 and DSP=1.
  - The default DEPTH=120.
- Natural sub-module: cap_rr_arb2, a 2-way round-robin arbiter. It has a registered last-served pointer and is updated on the ACK state. The FSM, counters and watchdog stay in cap_sched.

## Test plan
- Single host request, SKIP=0, continuous sample_valid_in:
  - gnt=01 after one edge.
  - Exactly 120 cap_en_out pulses.
  - mem_done one cycle, 3 cycles after the last pulse.
  - The buffer model returns out_done 121 cycles later, and ack=01 follows one cycle after that.
- Both req high in IDLE from reset: host served first, then DSP (gnt=10), then host again. There is one IDLE cycle between frames.
- Sparse sample_valid_in (every 3rd cycle), SKIP=4:
  - First 4 strobes are blocked.
  - Next 120 pass.
  - The buffer holds strobes 5..124 at addresses 0..119.
- No mem_out_done, TIMEOUT=255: DRAIN exits after 255 cycles, and ack and timeout_o pulse together.
- rstb low in mid-CAPTURE (sample 60): all outputs 0 immediately, no ack. A new request then captures a full 120-sample frame starting at buffer address 0.
- req[0] dropped mid-CAPTURE and mem_out_done pulsed during CAPTURE: the stray done is ignored, the frame completes, and ack=01 still pulses.
